// File: rtl/stdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stdp_pkg
// Description : Shared types, default constants and the saturating weight
//               update helper for the STDP synapse controller.
// Revision    : 1.0 - initial release
// ============================================================================
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    APPLY = 2'd2
  } stdp_state_t;

  localparam int c_w_init    = 128;
  localparam int c_a_plus    = 16;
  localparam int c_a_minus   = 12;
  localparam int c_tau_shift = 2;
  localparam int c_win       = 64;

  // Operands are widened to 32 bits so neither the sum nor the difference
  // can wrap before the result is clamped into [0, max_v].
  function automatic int unsigned sat_addsub(input int unsigned w,
                                             input int unsigned d,
                                             input logic        sub,
                                             input int unsigned max_v);
    int unsigned r;
    if (sub) begin
      r = (d > w) ? 32'd0 : (w - d);
    end else begin
      r = ((w + d) > max_v) ? max_v : (w + d);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spike_timer.sv
`default_nettype none
// ============================================================================
// Module      : spike_timer
// Description : Time-since-last-spike counter. A spike loads 1 and sets the
//               seen bit; otherwise the count saturates upward. Frozen when
//               en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          spike,
  output logic [TW-1:0] t,
  output logic          seen
);

  localparam logic [TW-1:0] c_t_max = '1;

  logic [TW-1:0] r_t;
  logic          r_seen;

  // Load on spike, otherwise saturating increment; everything holds when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t    <= c_t_max;
      r_seen <= 1'b0;
    end else if (en) begin
      if (spike) begin
        r_t    <= TW'(1);
        r_seen <= 1'b1;
      end else if (r_t != c_t_max) begin
        r_t    <= r_t + TW'(1);
      end
    end
  end

  assign t    = r_t;
  assign seen = r_seen;

endmodule
`default_nettype wire

// File: rtl/stdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stdp_ctrl
// Description : STDP sequencer for one synapse. Timestamps pre/post spikes,
//               detects causal/anti-causal pairings inside a window and
//               applies a shifted-exponential, saturating weight update.
// Revision    : 1.0 - initial release
// ============================================================================
module stdp_ctrl
  import stdp_pkg::*;
#(
  parameter int TW        = 8,
  parameter int WW        = 8,
  parameter int W_INIT    = c_w_init,
  parameter int A_PLUS    = c_a_plus,
  parameter int A_MINUS   = c_a_minus,
  parameter int TAU_SHIFT = c_tau_shift,
  parameter int WIN       = c_win
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pre_spike,
  input  logic          post_spike,
  output logic [WW-1:0] weight,
  output logic [TW-1:0] time_diff,
  output logic          update_flag,
  output logic          ltp,
  output logic          busy
);

  localparam logic [TW:0]   c_win_ext   = (TW+1)'(WIN);
  localparam logic [WW-1:0] c_a_plus_w  = WW'(A_PLUS);
  localparam logic [WW-1:0] c_a_minus_w = WW'(A_MINUS);
  localparam int unsigned   c_w_max     = (32'd1 << WW) - 32'd1;

  logic [TW-1:0] w_pre_t, w_post_t;
  logic          w_pre_seen, w_post_seen;
  logic          w_ltp_hit, w_ltd_hit;

  stdp_state_t   r_state, w_next_state;

  logic [TW-1:0] r_dt;
  logic          r_dir;
  logic [WW-1:0] r_delta;
  logic [WW-1:0] r_weight;
  logic [TW-1:0] r_time_diff;
  logic          r_ltp;
  logic          r_update_flag;

  logic [WW-1:0] w_a_sel;
  logic [TW-1:0] w_shift;
  logic [WW-1:0] w_delta;

  spike_timer #(.TW(TW)) u_pre_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .spike (pre_spike),
    .t     (w_pre_t),
    .seen  (w_pre_seen)
  );

  spike_timer #(.TW(TW)) u_post_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .spike (post_spike),
    .t     (w_post_t),
    .seen  (w_post_seen)
  );

  // A lone spike pairs with the opposite neuron's earlier spike if it falls
  // inside the window; simultaneous spikes are deliberately not a pairing.
  assign w_ltp_hit = en && post_spike && !pre_spike && w_pre_seen &&
                     ({1'b0, w_pre_t} < c_win_ext);
  assign w_ltd_hit = en && pre_spike && !post_spike && w_post_seen &&
                     ({1'b0, w_post_t} < c_win_ext);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next state: pairings are only taken in IDLE, so spikes seen while busy are dropped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_ltp_hit || w_ltd_hit) w_next_state = CALC;
      CALC:    w_next_state = APPLY;
      APPLY:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Exponential approximation: halve the base magnitude every 2^TAU_SHIFT cycles of dt.
  always_comb begin
    w_a_sel = r_dir ? c_a_plus_w : c_a_minus_w;
    w_shift = r_dt >> TAU_SHIFT;
    if (32'(w_shift) >= WW) w_delta = '0;
    else                    w_delta = w_a_sel >> w_shift;
  end

  // Datapath: latch the pairing, register delta/direction, then write the weight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dt          <= '0;
      r_dir         <= 1'b0;
      r_delta       <= '0;
      r_weight      <= WW'(W_INIT);
      r_time_diff   <= '0;
      r_ltp         <= 1'b0;
      r_update_flag <= 1'b0;
    end else begin
      r_update_flag <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ltp_hit) begin
            r_dt  <= w_pre_t;
            r_dir <= 1'b1;
          end else if (w_ltd_hit) begin
            r_dt  <= w_post_t;
            r_dir <= 1'b0;
          end
        end
        CALC: begin
          r_delta     <= w_delta;
          r_time_diff <= r_dt;
          r_ltp       <= r_dir;
        end
        APPLY: begin
          r_weight      <= WW'(sat_addsub(32'(r_weight), 32'(r_delta), !r_ltp, c_w_max));
          r_update_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign weight      = r_weight;
  assign time_diff   = r_time_diff;
  assign update_flag = r_update_flag;
  assign ltp         = r_ltp;
  assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
